de2_70_ethernet_st_ready_latency_adapter: RTL and testbench

DE2_70_ETHERNET_ST_READY_LATENCY_ADAPTER -- requirements
Module: de2_70_ethernet_st_ready_latency_adapter

---
 rtl/de2_70_ethernet_st_ready_latency_adapter.sv | 225 ++++++++++++++++++++++
 tb/tb_de2_70_ethernet_st_ready_latency_adapter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/de2_70_ethernet_st_ready_latency_adapter.sv
// -----------------------------------------------------------------------------
// de2_70_ethernet_st_ready_latency_adapter
//
// Purpose: bridges a ready-latency-0 streaming sink to a streaming source with
// ready latency OUT_READY_LATENCY. Accepted beats are buffered in a small FIFO
// and launched into a registered output stage only when the delayed copy of
// out_ready allows it. A passive framing monitor watches the output beats,
// counts completed packets and flags sop/eop ordering violations.
//
// Ports:
//   clk, reset_n               sole clock, synchronous active-low reset
//   in_valid / in_ready        sink handshake (ready latency 0)
//   in_data/error/sop/eop/empty  sink payload (32/1/1/1/2)
//   out_ready                  source ready (ready latency OUT_READY_LATENCY)
//   out_valid, out_data/error/sop/eop/empty  registered source beat
//   err_clear                  clears proto_err (a same-cycle violation wins)
//   proto_err                  sticky framing violation flag
//   pkt_count                  completed output packets, wraps at 16 bits
// -----------------------------------------------------------------------------
module de2_70_ethernet_st_ready_latency_adapter #(
   parameter int unsigned OUT_READY_LATENCY = 2,
   parameter int unsigned FIFO_DEPTH        = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_error,
   input  logic        in_startofpacket,
   input  logic        in_endofpacket,
   input  logic [1:0]  in_empty,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] out_data,
   output logic        out_error,
   output logic        out_startofpacket,
   output logic        out_endofpacket,
   output logic [1:0]  out_empty,
   input  logic        err_clear,
   output logic        proto_err,
   output logic [15:0] pkt_count
);

   localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW   = PW + 1;
   localparam int unsigned PL_W = 37;

   typedef enum logic {
      ST_IDLE,
      ST_PKT
   } state_t;

   logic [PL_W-1:0] mem_q [FIFO_DEPTH];
   logic [PL_W-1:0] mem_d [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            out_valid_q, out_valid_d;
   logic [PL_W-1:0] out_pl_q, out_pl_d;
   state_t          state_q, state_d;
   logic            proto_err_q, proto_err_d;
   logic [15:0]     pkt_count_q, pkt_count_d;

   logic [PL_W-1:0] in_pl;
   logic            tap;
   logic            push;
   logic            load;
   logic            viol;
   logic            pkt_done;

   assign in_pl = {in_data, in_error, in_startofpacket, in_endofpacket, in_empty};

   // Ready depends only on the registered count; gating with reset_n keeps it
   // low during the reset cycle itself.
   assign in_ready = reset_n & (count_q < CW'(FIFO_DEPTH));
   assign push     = in_valid & in_ready;
   assign load     = tap & (count_q != '0);

   // --------------------------------------------------------------------------
   // Delayed out_ready: tap is out_ready as it was OUT_READY_LATENCY-1 cycles
   // ago, so a beat launched now lands exactly OUT_READY_LATENCY cycles after
   // the matching ready.
   // --------------------------------------------------------------------------
   if (OUT_READY_LATENCY == 1) begin : g_tap_direct
      always_comb begin
         tap = out_ready;
      end
   end else begin : g_tap_sr
      logic [OUT_READY_LATENCY-2:0] rdy_sr_q, rdy_sr_d;

      always_comb begin
         rdy_sr_d    = rdy_sr_q;
         rdy_sr_d[0] = out_ready;
         for (int unsigned i = 1; i < OUT_READY_LATENCY - 1; i++) begin
            rdy_sr_d[i] = rdy_sr_q[i-1];
         end
         tap = rdy_sr_q[OUT_READY_LATENCY-2];
      end

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            rdy_sr_q <= '0;
         end else begin
            rdy_sr_q <= rdy_sr_d;
         end
      end
   end

   // --------------------------------------------------------------------------
   // FIFO and output stage
   // --------------------------------------------------------------------------
   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_valid_d = load;
      out_pl_d    = out_pl_q;

      if (push) begin
         mem_d[wr_ptr_q] = in_pl;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end

      // Head is read from the pre-edge memory; a same-cycle push only ever
      // writes the tail slot, so the head is never overwritten here.
      if (load) begin
         out_pl_d = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PW'(1);
      end

      case ({push, load})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_pl_q    <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_pl_q    <= out_pl_d;
      end
   end

   // --------------------------------------------------------------------------
   // Framing monitor: observes output beats only, never feeds back into the
   // data path.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      viol     = 1'b0;
      pkt_done = 1'b0;

      if (out_valid_q) begin
         case (state_q)
            ST_IDLE: begin
               if (!out_pl_q[3]) begin
                  viol = 1'b1;
               end else if (out_pl_q[2]) begin
                  pkt_done = 1'b1;
               end else begin
                  state_d = ST_PKT;
               end
            end
            ST_PKT: begin
               if (out_pl_q[3]) begin
                  viol = 1'b1;
                  if (out_pl_q[2]) begin
                     pkt_done = 1'b1;
                     state_d  = ST_IDLE;
                  end
               end else if (out_pl_q[2]) begin
                  pkt_done = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      proto_err_d = err_clear ? 1'b0 : proto_err_q;
      if (viol) begin
         proto_err_d = 1'b1;
      end

      pkt_count_d = pkt_count_q + {15'd0, pkt_done};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         proto_err_q <= 1'b0;
         pkt_count_q <= '0;
      end else begin
         state_q     <= state_d;
         proto_err_q <= proto_err_d;
         pkt_count_q <= pkt_count_d;
      end
   end

   assign out_valid         = out_valid_q;
   assign out_data          = out_pl_q[36:5];
   assign out_error         = out_pl_q[4];
   assign out_startofpacket = out_pl_q[3];
   assign out_endofpacket   = out_pl_q[2];
   assign out_empty         = out_pl_q[1:0];
   assign proto_err         = proto_err_q;
   assign pkt_count         = pkt_count_q;

endmodule

// File: tb/tb_de2_70_ethernet_st_ready_latency_adapter.sv
module tb_de2_70_ethernet_st_ready_latency_adapter;

   localparam int unsigned LAT   = 2;
   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_error;
   logic        in_startofpacket;
   logic        in_endofpacket;
   logic [1:0]  in_empty;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_error;
   logic        out_startofpacket;
   logic        out_endofpacket;
   logic [1:0]  out_empty;
   logic        err_clear;
   logic        proto_err;
   logic [15:0] pkt_count;

   de2_70_ethernet_st_ready_latency_adapter #(
      .OUT_READY_LATENCY (LAT),
      .FIFO_DEPTH        (DEPTH)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_data           (in_data),
      .in_error          (in_error),
      .in_startofpacket  (in_startofpacket),
      .in_endofpacket    (in_endofpacket),
      .in_empty          (in_empty),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_error         (out_error),
      .out_startofpacket (out_startofpacket),
      .out_endofpacket   (out_endofpacket),
      .out_empty         (out_empty),
      .err_clear         (err_clear),
      .proto_err         (proto_err),
      .pkt_count         (pkt_count)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Reference model state: an ordered queue of accepted beats plus the
   // history of out_ready, framing tracked from the packet rules.
   logic [36:0] fifo_q[$];
   bit          rdy_hist [LAT];
   bit          exp_valid;
   logic [36:0] exp_beat;
   bit          in_pkt;
   bit          exp_err;
   logic [15:0] exp_cnt;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_edge();
      bit          tap;
      bit          accept;
      bit          sop;
      bit          eop;
      bit          viol;
      if (!reset_n) begin
         fifo_q.delete();
         for (int i = 0; i < LAT; i++) rdy_hist[i] = 1'b0;
         exp_valid = 1'b0;
         exp_beat  = '0;
         in_pkt    = 1'b0;
         exp_err   = 1'b0;
         exp_cnt   = '0;
         return;
      end
      // rdy_hist[k] = out_ready k+1 cycles ago; need out_ready from LAT-1 ago
      tap    = (LAT == 1) ? out_ready : rdy_hist[LAT-2];
      accept = in_valid && (fifo_q.size() < DEPTH);

      viol = 1'b0;
      if (exp_valid) begin
         sop = exp_beat[3];
         eop = exp_beat[2];
         if (!in_pkt) begin
            if (!sop)     viol = 1'b1;
            else if (eop) exp_cnt++;
            else          in_pkt = 1'b1;
         end else if (sop) begin
            viol = 1'b1;
            if (eop) begin in_pkt = 1'b0; exp_cnt++; end
         end else if (eop) begin
            in_pkt = 1'b0;
            exp_cnt++;
         end
      end
      if (err_clear) exp_err = 1'b0;
      if (viol)      exp_err = 1'b1;

      exp_valid = tap && (fifo_q.size() > 0);
      if (exp_valid) exp_beat = fifo_q.pop_front();
      if (accept) fifo_q.push_back({in_data, in_error, in_startofpacket, in_endofpacket, in_empty});

      for (int i = LAT - 1; i > 0; i--) rdy_hist[i] = rdy_hist[i-1];
      rdy_hist[0] = out_ready;
   endfunction

   task automatic check_all();
      chk("out_valid", out_valid, exp_valid);
      chk("out_beat", {out_data, out_error, out_startofpacket, out_endofpacket, out_empty}, exp_beat);
      chk("in_ready", in_ready, reset_n && (fifo_q.size() < DEPTH));
      chk("proto_err", proto_err, exp_err);
      chk("pkt_count", pkt_count, exp_cnt);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic drive(input bit v, input bit sop, input bit eop);
      in_valid         = v;
      in_data          = $urandom;
      in_error         = 1'($urandom_range(0, 1));
      in_startofpacket = sop;
      in_endofpacket   = eop;
      in_empty         = 2'($urandom_range(0, 3));
   endtask

   task automatic do_reset(input int unsigned n);
      reset_n = 1'b0;
      for (int i = 0; i < n; i++) cycle();
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n   = 1'b0;
      out_ready = 1'b0;
      err_clear = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      do_reset(2);

      // Single-beat packet with out_ready held high: minimum latency
      out_ready = 1'b1;
      cycle(); cycle();
      drive(1'b1, 1'b1, 1'b1);
      in_data = 32'hA5A5_A5A5;
      cycle();                       // push edge E
      drive(1'b0, 1'b0, 1'b0);
      cycle();                       // pop edge E+1
      chk("lat_valid", out_valid, 1'b1);
      chk("lat_data", out_data, 32'hA5A5_A5A5);
      cycle();
      chk("lat_pkt_count", pkt_count, 16'd1);
      chk("lat_proto_err", proto_err, 1'b0);

      // Backpressure: five back-to-back attempts, only four fit
      out_ready = 1'b0;
      cycle(); cycle(); cycle();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, i == 0, i == 3);
         cycle();
      end
      drive(1'b0, 1'b0, 1'b0);
      chk("full_in_ready", in_ready, 1'b0);
      cycle(); cycle();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) cycle();

      // Full FIFO drained by a toggling ready
      out_ready = 1'b0;
      cycle(); cycle();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 1'b1);
         cycle();
      end
      drive(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         out_ready = (i % 2 == 0);
         cycle();
      end

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
         out_ready = $urandom_range(0, 2) != 0;
         err_clear = $urandom_range(0, 15) == 0;
         cycle();
      end
      drive(1'b0, 1'b0, 1'b0);
      err_clear = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) cycle();

      // Violation from IDLE, sticky, then clear; clear coincident with violations
      drive(1'b1, 1'b1, 1'b1);
      cycle();
      drive(1'b1, 1'b0, 1'b0);
      cycle();
      drive(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle();
      chk("err_sticky", proto_err, 1'b1);
      err_clear = 1'b1;
      cycle();
      err_clear = 1'b0;
      cycle();
      chk("err_cleared", proto_err, 1'b0);
      err_clear = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0);
         cycle();
      end
      drive(1'b0, 1'b0, 1'b0);
      cycle(); cycle();
      chk("err_clear_vs_viol", proto_err, 1'b1);
      err_clear = 1'b0;
      cycle();

      // Reset with beats buffered
      out_ready = 1'b0;
      cycle(); cycle();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, i == 0, 1'b0);
         cycle();
      end
      drive(1'b0, 1'b0, 1'b0);
      do_reset(1);
      out_ready = 1'b1;
      cycle();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_pkt_count", pkt_count, 16'd0);
      drive(1'b1, 1'b1, 1'b0);
      cycle();
      drive(1'b1, 1'b0, 1'b1);
      cycle();
      drive(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle();
      chk("rst_new_pkt", pkt_count, 16'd1);
      chk("rst_new_err", proto_err, 1'b0);

      // Packet counter wrap
      do_reset(1);
      out_ready = 1'b1;
      cycle(); cycle();
      for (int i = 0; i < 65535; i++) begin
         drive(1'b1, 1'b1, 1'b1);
         cycle();
      end
      drive(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle();
      chk("cnt_max", pkt_count, 16'hFFFF);
      drive(1'b1, 1'b1, 1'b1);
      cycle();
      drive(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle();
      chk("cnt_wrap", pkt_count, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
